zueirai_gpio_ctrl: RTL

//  CPU-side register bank for the three 8-bit GPIO ports (A/B/C). Holds per-port direction and output latches.

---
 rtl/zueirai_gpio_pkg.sv | 25 ++
 rtl/zueirai_gpio_sync.sv | 26 ++
 rtl/zueirai_gpio_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/zueirai_gpio_pkg.sv
// Shared types and register-map constants for the GPIO register bank.
package zueirai_gpio_pkg;

  typedef enum logic [1:0] {
    PORT_A   = 2'd0,
    PORT_B   = 2'd1,
    PORT_C   = 2'd2,
    PORT_IRQ = 2'd3
  } port_e;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] REG_DIR  = 2'd0;
  localparam logic [1:0] REG_OUT  = 2'd1;
  localparam logic [1:0] REG_IN   = 2'd2;
  localparam logic [1:0] REG_TGL  = 2'd3;
  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_IEN  = 2'd1;

  localparam logic [3:0] ADDR_PEND = {PORT_IRQ, REG_PEND};
  localparam logic [3:0] ADDR_IEN  = {PORT_IRQ, REG_IEN};

  typedef logic [7:0] gpio_byte_t;

endpackage

// File: rtl/zueirai_gpio_sync.sv
// 8-bit multi-flop synchroniser for asynchronous pin inputs.
module zueirai_gpio_sync
  import zueirai_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  gpio_byte_t d,
  output gpio_byte_t q
);

  gpio_byte_t stage_reg [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/zueirai_gpio_ctrl.sv
// CPU register bank for GPIO ports A/B/C: direction/output latches, synchronised inputs.
// Define ZUEIRAI_GPIO_IRQ_EN to add the pin-change interrupt block (PEND/IEN at addr 12/13).
module zueirai_gpio_ctrl
  import zueirai_gpio_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_DIR   = 8'h00,
  parameter logic [7:0] RESET_OUT   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic [7:0] dir_a,
  output logic [7:0] dir_b,
  output logic [7:0] dir_c,
  output logic [7:0] out_a,
  output logic [7:0] out_b,
  output logic [7:0] out_c,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_c,
  output logic       irq
);

  gpio_byte_t dir_reg  [NUM_PORTS];
  gpio_byte_t out_reg  [NUM_PORTS];
  gpio_byte_t pin_in   [NUM_PORTS];
  gpio_byte_t sync_val [NUM_PORTS];
  gpio_byte_t in_val   [NUM_PORTS];
  gpio_byte_t rdata_reg, rdata_next;
  logic       rvalid_reg;

  assign pin_in[0] = in_a;
  assign pin_in[1] = in_b;
  assign pin_in[2] = in_c;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    zueirai_gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pin_in[gi]),
      .q   (sync_val[gi])
    );
    // Driven bits read back their own latch; undriven bits read the pin.
    assign in_val[gi] = (dir_reg[gi] & out_reg[gi]) | (~dir_reg[gi] & sync_val[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        dir_reg[p] <= RESET_DIR;
        out_reg[p] <= RESET_OUT;
      end
    end else if (we) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (addr[3:2] == 2'(p)) begin
          case (addr[1:0])
            REG_DIR: dir_reg[p] <= wdata;
            REG_OUT: out_reg[p] <= wdata;
            REG_TGL: out_reg[p] <= out_reg[p] ^ wdata;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef ZUEIRAI_GPIO_IRQ_EN
  gpio_byte_t prev_reg [NUM_PORTS];
  logic [2:0] chg_any, pend_clr, pend_reg, pend_next, ien_reg;
  logic       irq_reg;

  always_comb begin
    chg_any = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      chg_any[p] = |((sync_val[p] ^ prev_reg[p]) & ~dir_reg[p]);
  end

  // A new event in the same cycle as its W1C clear keeps the bit set.
  assign pend_clr  = (we && addr == ADDR_PEND) ? wdata[2:0] : 3'b000;
  assign pend_next = (pend_reg & ~pend_clr) | chg_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) prev_reg[p] <= '0;
      pend_reg <= '0;
      ien_reg  <= '0;
      irq_reg  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) prev_reg[p] <= sync_val[p];
      pend_reg <= pend_next;
      if (we && addr == ADDR_IEN) ien_reg <= wdata[2:0];
      irq_reg <= |(pend_reg & ien_reg);
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addr[3:2] == 2'(p)) begin
        case (addr[1:0])
          REG_DIR: rdata_next = dir_reg[p];
          REG_OUT: rdata_next = out_reg[p];
          REG_IN:  rdata_next = in_val[p];
          default: rdata_next = '0;
        endcase
      end
    end
`ifdef ZUEIRAI_GPIO_IRQ_EN
    if (addr == ADDR_PEND) rdata_next = {5'b0, pend_reg};
    if (addr == ADDR_IEN)  rdata_next = {5'b0, ien_reg};
`endif
  end

  // Reads sample pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= re;
      if (re) rdata_reg <= rdata_next;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign dir_a  = dir_reg[0];
  assign dir_b  = dir_reg[1];
  assign dir_c  = dir_reg[2];
  assign out_a  = out_reg[0];
  assign out_b  = out_reg[1];
  assign out_c  = out_reg[2];

endmodule
